// File: rtl/mic1_mem_responder.sv
// mic1_mem_responder
// Memory-side responder for the CPU's serialized 8-bit memory port. A
// transaction is a 4-byte word address (LSB first). For a write, 4 data
// bytes (LSB first) follow and are committed to a local word memory. For a
// read, the addressed word is returned as 4 bytes (LSB first).
//
// Optional feature: define MEM_TIMEOUT_EN to abort a transaction (done+err)
// after TIMEOUT_CYCLES idle enabled cycles between bytes in ADDR or WDATA.
//
// Handshake: bus_valid qualifies bus_in for one cycle. There is no ready.
// The responder takes a byte on every bus_valid=1 cycle in IDLE/ADDR/WDATA
// and ignores bytes in all other states. data_valid marks data_out for one
// cycle, with no backpressure. done (and err, when flagged) pulses once
// per transaction.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   ena                 global enable; when low every register holds
//   bus_in, bus_valid   address / write-data byte from the CPU
//   bus_cmd             01 read, 10 write (sampled on the first byte)
//   data_out, data_valid  read-data byte stream
//   busy                high whenever the FSM is not in IDLE
//   done, err           completion pulse / out-of-range or timeout flag
//   state (internal)    FSM state, left visible for debug probing
module mic1_mem_responder #(
  parameter int ADDR_W         = 4,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] bus_in,
  input  logic       bus_valid,
  input  logic [1:0] bus_cmd,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_WDATA, S_WR_COMMIT, S_RD_ISSUE, S_RDATA
  } state_t;

  state_t      state;
  logic        is_write;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic [31:0] rword;
  logic        rd_err;
  logic [2:0]  cnt;

  logic [31:0] mem [2**ADDR_W];

  logic              addr_oor;
  logic [ADDR_W-1:0] widx;

  assign addr_oor = (addr_q >> ADDR_W) != 32'h0;
  assign widx     = addr_q[ADDR_W-1:0];

`ifdef MEM_TIMEOUT_EN
  localparam logic [3:0] TO_LAST = 4'(TIMEOUT_CYCLES - 1);
  logic [3:0] gap_cnt;
  logic       gap_expire;

  // Expiry fires on the TIMEOUT_CYCLES-th consecutive idle enabled cycle.
  assign gap_expire = ((state == S_ADDR) || (state == S_WDATA)) &&
                      !bus_valid && (gap_cnt == TO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_cnt <= 4'h0;
    end else if (ena) begin
      if (((state == S_ADDR) || (state == S_WDATA)) && !bus_valid && !gap_expire)
        gap_cnt <= gap_cnt + 4'h1;
      else
        gap_cnt <= 4'h0;
    end
  end
`endif

  // Word memory is deliberately not reset. The state check keeps a
  // transaction aborted by reset from ever reaching it.
  always_ff @(posedge clk) begin
    if (ena && rst_n && (state == S_WR_COMMIT) && !addr_oor)
      mem[widx] <= data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      is_write   <= 1'b0;
      addr_q     <= 32'h0;
      data_q     <= 32'h0;
      rword      <= 32'h0;
      rd_err     <= 1'b0;
      cnt        <= 3'd0;
      data_out   <= 8'h0;
      data_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else if (ena) begin
      // Pulsed outputs default low and are raised only where needed.
      data_out   <= 8'h0;
      data_valid <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus_valid && ((bus_cmd == 2'b01) || (bus_cmd == 2'b10))) begin
            is_write <= (bus_cmd == 2'b10);
            addr_q   <= {24'h0, bus_in};
            cnt      <= 3'd1;
            state    <= S_ADDR;
            busy     <= 1'b1;
          end
        end
        S_ADDR: begin
          if (bus_valid) begin
            addr_q[{cnt[1:0], 3'b000} +: 8] <= bus_in;
            if (cnt == 3'd3) begin
              cnt   <= 3'd0;
              state <= is_write ? S_WDATA : S_RD_ISSUE;
            end else begin
              cnt <= cnt + 3'd1;
            end
          end
`ifdef MEM_TIMEOUT_EN
          else if (gap_expire) begin
            cnt   <= 3'd0;
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            err   <= 1'b1;
          end
`endif
        end
        S_WDATA: begin
          if (bus_valid) begin
            data_q[{cnt[1:0], 3'b000} +: 8] <= bus_in;
            if (cnt == 3'd3) begin
              // done/err are shown during the commit cycle itself.
              cnt   <= 3'd0;
              state <= S_WR_COMMIT;
              done  <= 1'b1;
              err   <= addr_oor;
            end else begin
              cnt <= cnt + 3'd1;
            end
          end
`ifdef MEM_TIMEOUT_EN
          else if (gap_expire) begin
            cnt   <= 3'd0;
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            err   <= 1'b1;
          end
`endif
        end
        S_WR_COMMIT: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        S_RD_ISSUE: begin
          rword  <= addr_oor ? 32'h0 : mem[widx];
          rd_err <= addr_oor;
          cnt    <= 3'd0;
          state  <= S_RDATA;
        end
        S_RDATA: begin
          // cnt 0..3 emit bytes. cnt 4 is the cycle following done,
          // which returns to IDLE so busy stays high through done.
          if (cnt != 3'd4) begin
            data_out   <= rword[{cnt[1:0], 3'b000} +: 8];
            data_valid <= 1'b1;
            cnt        <= cnt + 3'd1;
            if (cnt == 3'd3) begin
              done <= 1'b1;
              err  <= rd_err;
            end
          end else begin
            cnt   <= 3'd0;
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mic1_mem_responder.sv
module tb_mic1_mem_responder;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] bus_in;
  logic       bus_valid;
  logic [1:0] bus_cmd;
  logic [7:0] data_out;
  logic       data_valid;
  logic       busy;
  logic       done;
  logic       err;

  always #5 clk = ~clk;

  mic1_mem_responder #(.ADDR_W(4), .TIMEOUT_CYCLES(15)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .bus_in     (bus_in),
    .bus_valid  (bus_valid),
    .bus_cmd    (bus_cmd),
    .data_out   (data_out),
    .data_valid (data_valid),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  int n_checks = 0;
  int n_fails  = 0;

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus_valid = 1'b1;
    bus_in    = b;
    tick();
    bus_valid = 1'b0;
  endtask

  task automatic send_addr(input logic [1:0] cmd, input logic [31:0] a, input int gap);
    bus_cmd = cmd;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) repeat (gap) tick();
      send_byte(a[8*i +: 8]);
      if (i == 0) chk("busy_after_first_byte", busy, 1);
    end
    bus_cmd = 2'b00;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input int gap,
                          input logic exp_err);
    send_addr(2'b10, a, gap);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) repeat (gap) tick();
      send_byte(d[8*i +: 8]);
    end
    chk("wr_done", done, 1);
    chk("wr_err", err, exp_err);
    chk("wr_busy_in_done", busy, 1);
    tick();
    chk("wr_done_clear", done, 0);
    chk("wr_busy_clear", busy, 0);
  endtask

  task automatic do_read(input logic [31:0] a, input logic [31:0] w, input logic exp_err);
    send_addr(2'b01, a, 0);
    chk("rd_issue_dv", data_valid, 0);
    tick();
    chk("rd_n1_dv", data_valid, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rd_dv", data_valid, 1);
      chk("rd_byte", data_out, w[8*i +: 8]);
      chk("rd_done", done, (i == 3) ? 1 : 0);
      chk("rd_err", err, (i == 3) ? exp_err : 1'b0);
    end
    tick();
    chk("rd_after_dv", data_valid, 0);
    chk("rd_after_done", done, 0);
    chk("rd_after_busy", busy, 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n     = 1'b0;
    ena       = 1'b1;
    bus_valid = 1'b0;
    bus_in    = 8'h00;
    bus_cmd   = 2'b00;
    #1;
    chk("rst_data_out", data_out, 0);
    chk("rst_data_valid", data_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    #20;
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Seed word 0 so later out-of-range writes can be shown not to touch it.
    do_write(32'h0000_0000, 32'hA5A5_A5A5, 0, 1'b0);

    // Basic write then read-back.
    do_write(32'h0000_0003, 32'hDEAD_BEEF, 0, 1'b0);
    do_read(32'h0000_0003, 32'hDEAD_BEEF, 1'b0);

    // Out-of-range read and write.
    do_read(32'h0000_0100, 32'h0000_0000, 1'b1);
    do_write(32'h0000_0100, 32'h1111_1111, 0, 1'b1);
    do_read(32'h0000_0000, 32'hA5A5_A5A5, 1'b0);

    // Gaps of 3 idle cycles between every byte.
    do_write(32'h0000_0005, 32'h1234_5678, 3, 1'b0);
    do_read(32'h0000_0005, 32'h1234_5678, 1'b0);

`ifdef MEM_TIMEOUT_EN
    // 15 idle cycles after address byte 2 aborts with done+err.
    bus_cmd = 2'b10;
    send_byte(8'h09);
    send_byte(8'h00);
    send_byte(8'h00);
    bus_cmd = 2'b00;
    repeat (14) tick();
    chk("to_not_yet_done", done, 0);
    chk("to_not_yet_busy", busy, 1);
    tick();
    chk("to_done", done, 1);
    chk("to_err", err, 1);
    chk("to_busy", busy, 0);
    tick();
    chk("to_done_clear", done, 0);
    do_read(32'h0000_0003, 32'hDEAD_BEEF, 1'b0);
`else
    // Without the timeout a long gap is simply waited out.
    bus_cmd = 2'b10;
    send_byte(8'h09);
    send_byte(8'h00);
    send_byte(8'h00);
    bus_cmd = 2'b00;
    repeat (20) tick();
    chk("long_gap_busy", busy, 1);
    chk("long_gap_done", done, 0);
    send_byte(8'h00);
    send_byte(8'h44);
    send_byte(8'h33);
    send_byte(8'h22);
    send_byte(8'h11);
    chk("long_gap_wr_done", done, 1);
    chk("long_gap_wr_err", err, 0);
    tick();
    do_read(32'h0000_0009, 32'h1122_3344, 1'b0);
`endif

    // ena low for 4 cycles while byte 1 is on the output.
    send_addr(2'b01, 32'h0000_0003, 0);
    tick();
    tick();
    chk("ena_b0", data_out, 8'hEF);
    tick();
    chk("ena_b1", data_out, 8'hBE);
    ena = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("ena_hold_byte", data_out, 8'hBE);
      chk("ena_hold_dv", data_valid, 1);
      chk("ena_hold_done", done, 0);
    end
    ena = 1'b1;
    tick();
    chk("ena_b2", data_out, 8'hAD);
    chk("ena_b2_done", done, 0);
    tick();
    chk("ena_b3", data_out, 8'hDE);
    chk("ena_b3_done", done, 1);
    tick();
    chk("ena_end_busy", busy, 0);

    // Asynchronous reset after 2 write-data bytes.
    send_addr(2'b10, 32'h0000_0003, 0);
    send_byte(8'h0D);
    send_byte(8'hF0);
    chk("prerst_busy", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_dv", data_valid, 0);
    chk("async_rst_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    do_read(32'h0000_0003, 32'hDEAD_BEEF, 1'b0);

    // Illegal commands leave the block idle.
    bus_cmd = 2'b00;
    send_byte(8'h55);
    chk("cmd00_busy", busy, 0);
    bus_cmd = 2'b11;
    send_byte(8'h55);
    chk("cmd11_busy", busy, 0);
    bus_cmd = 2'b00;

    // Back-to-back: the read starts in the cycle right after the write.
    do_write(32'h0000_0007, 32'h0BAD_F00D, 0, 1'b0);
    do_read(32'h0000_0007, 32'h0BAD_F00D, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  // Guard against anything stalling the sequence.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
